// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480@60), lock-state encoding and a small decode helper.
package vga_pkg;

  localparam int unsigned TotalCols   = 800;
  localparam int unsigned TotalRows   = 525;
  localparam int unsigned ActiveCols  = 640;
  localparam int unsigned ActiveRows  = 480;
  localparam int unsigned HFrontPorch = 18;
  localparam int unsigned HBackPorch  = 50;
  localparam int unsigned VFrontPorch = 10;
  localparam int unsigned VBackPorch  = 33;
  localparam int unsigned VideoWidth  = 4;
  localparam int unsigned CountWidth  = 10;

  typedef enum logic {
    StUnlocked = 1'b0,
    StLocked   = 1'b1
  } lock_state_e;

  // Half-open window test: lo <= val < hi.
  function automatic logic in_window(input logic [CountWidth-1:0] val,
                                     input logic [CountWidth-1:0] lo,
                                     input logic [CountWidth-1:0] hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Frame-start detect, col/row position counters and a one-cycle delay of the syncs and video,
// so the position outputs are aligned with the delayed pixel.
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int unsigned NumCols  = TotalCols,
  parameter int unsigned NumRows  = TotalRows,
  parameter int unsigned Width    = VideoWidth,
  parameter int unsigned CntWidth = CountWidth
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                hsync_i,
  input  logic                vsync_i,
  input  logic [Width-1:0]    red_i,
  input  logic [Width-1:0]    grn_i,
  input  logic [Width-1:0]    blu_i,
  output logic                frame_start_o,
  output logic [CntWidth-1:0] col_o,
  output logic [CntWidth-1:0] row_o,
  output logic                hsync_o,
  output logic                vsync_o,
  output logic [Width-1:0]    red_o,
  output logic [Width-1:0]    grn_o,
  output logic [Width-1:0]    blu_o
);

  localparam logic [CntWidth-1:0] ColLast = CntWidth'(NumCols - 1);
  localparam logic [CntWidth-1:0] RowLast = CntWidth'(NumRows - 1);

  logic                vsync_q;
  logic                hsync_q;
  logic [CntWidth-1:0] col_q, col_d;
  logic [CntWidth-1:0] row_q, row_d;
  logic [Width-1:0]    red_q;
  logic [Width-1:0]    grn_q;
  logic [Width-1:0]    blu_q;

  assign frame_start_o = vsync_i & ~vsync_q;

  always_comb begin
    col_d = col_q + CntWidth'(1);
    row_d = row_q;
    if (frame_start_o) begin
      col_d = '0;
      row_d = '0;
    end else if (col_q == ColLast) begin
      col_d = '0;
      row_d = (row_q == RowLast) ? '0 : row_q + CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // Reset high: a source already inside its active rows must not look like a frame start.
      vsync_q <= 1'b1;
      hsync_q <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      red_q   <= '0;
      grn_q   <= '0;
      blu_q   <= '0;
    end else begin
      vsync_q <= vsync_i;
      hsync_q <= hsync_i;
      col_q   <= col_d;
      row_q   <= row_d;
      red_q   <= red_i;
      grn_q   <= grn_i;
      blu_q   <= blu_i;
    end
  end

  assign col_o   = col_q;
  assign row_o   = row_q;
  assign hsync_o = hsync_q;
  assign vsync_o = vsync_q;
  assign red_o   = red_q;
  assign grn_o   = grn_q;
  assign blu_o   = blu_q;

endmodule

// File: rtl/vga_sync_porch.sv
// VGA output stage: regenerates active-low syncs with porches from the renderer's active-area
// syncs, blanks video outside the visible area and stays idle until the first frame start.
module vga_sync_porch
  import vga_pkg::*;
#(
  parameter int unsigned TOTAL_COLS    = TotalCols,
  parameter int unsigned TOTAL_ROWS    = TotalRows,
  parameter int unsigned ACTIVE_COLS   = ActiveCols,
  parameter int unsigned ACTIVE_ROWS   = ActiveRows,
  parameter int unsigned H_FRONT_PORCH = HFrontPorch,
  parameter int unsigned H_BACK_PORCH  = HBackPorch,
  parameter int unsigned V_FRONT_PORCH = VFrontPorch,
  parameter int unsigned V_BACK_PORCH  = VBackPorch,
  parameter int unsigned VIDEO_WIDTH   = VideoWidth
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  input  logic                   i_HSync,
  input  logic                   i_VSync,
  input  logic [VIDEO_WIDTH-1:0] i_Red_Video,
  input  logic [VIDEO_WIDTH-1:0] i_Grn_Video,
  input  logic [VIDEO_WIDTH-1:0] i_Blu_Video,
  output logic                   o_HSync,
  output logic                   o_VSync,
  output logic [VIDEO_WIDTH-1:0] o_Red_Video,
  output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
  output logic [VIDEO_WIDTH-1:0] o_Blu_Video,
  output logic                   o_Locked
);

  localparam logic [CountWidth-1:0] HsStart   = CountWidth'(ACTIVE_COLS + H_FRONT_PORCH);
  localparam logic [CountWidth-1:0] HsEnd     = CountWidth'(TOTAL_COLS - H_BACK_PORCH);
  localparam logic [CountWidth-1:0] VsStart   = CountWidth'(ACTIVE_ROWS + V_FRONT_PORCH);
  localparam logic [CountWidth-1:0] VsEnd     = CountWidth'(TOTAL_ROWS - V_BACK_PORCH);
  localparam logic [CountWidth-1:0] ColActive = CountWidth'(ACTIVE_COLS);
  localparam logic [CountWidth-1:0] RowActive = CountWidth'(ACTIVE_ROWS);

  logic                   frame_start;
  logic [CountWidth-1:0]  col;
  logic [CountWidth-1:0]  row;
  logic [VIDEO_WIDTH-1:0] red_dly;
  logic [VIDEO_WIDTH-1:0] grn_dly;
  logic [VIDEO_WIDTH-1:0] blu_dly;
  logic                   unused_hsync;
  logic                   unused_vsync;

  lock_state_e            state_q, state_d;
  logic                   hsync_q, hsync_d;
  logic                   vsync_q, vsync_d;
  logic [VIDEO_WIDTH-1:0] red_q, red_d;
  logic [VIDEO_WIDTH-1:0] grn_q, grn_d;
  logic [VIDEO_WIDTH-1:0] blu_q, blu_d;
  logic                   locked_q, locked_d;

  vga_sync_counter #(
    .NumCols  (TOTAL_COLS),
    .NumRows  (TOTAL_ROWS),
    .Width    (VIDEO_WIDTH),
    .CntWidth (CountWidth)
  ) u_counter (
    .clk_i         (i_Clk),
    .rst_ni        (i_Rst_L),
    .hsync_i       (i_HSync),
    .vsync_i       (i_VSync),
    .red_i         (i_Red_Video),
    .grn_i         (i_Grn_Video),
    .blu_i         (i_Blu_Video),
    .frame_start_o (frame_start),
    .col_o         (col),
    .row_o         (row),
    .hsync_o       (unused_hsync),
    .vsync_o       (unused_vsync),
    .red_o         (red_dly),
    .grn_o         (grn_dly),
    .blu_o         (blu_dly)
  );

  // Lock is sticky until reset; later frame starts only re-align the counters.
  always_comb begin
    state_d = state_q;
    if ((state_q == StUnlocked) && frame_start) begin
      state_d = StLocked;
    end
  end

  always_comb begin
    hsync_d  = 1'b1;
    vsync_d  = 1'b1;
    red_d    = '0;
    grn_d    = '0;
    blu_d    = '0;
    locked_d = (state_q == StLocked);
    if (state_q == StLocked) begin
      hsync_d = ~in_window(col, HsStart, HsEnd);
      vsync_d = ~in_window(row, VsStart, VsEnd);
      if ((col < ColActive) && (row < RowActive)) begin
        red_d = red_dly;
        grn_d = grn_dly;
        blu_d = blu_dly;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q  <= StUnlocked;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      red_q    <= '0;
      grn_q    <= '0;
      blu_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      red_q    <= red_d;
      grn_q    <= grn_d;
      blu_q    <= blu_d;
      locked_q <= locked_d;
    end
  end

  assign o_HSync     = hsync_q;
  assign o_VSync     = vsync_q;
  assign o_Red_Video = red_q;
  assign o_Grn_Video = grn_q;
  assign o_Blu_Video = blu_q;
  assign o_Locked    = locked_q;

endmodule

// File: tb/tb_vga_sync_porch.sv
// Bench for vga_sync_porch: boundary vectors from a table plus a per-pixel expected-output queue.
module tb_vga_sync_porch;

  // Short frame; horizontal timing is the 640x480 default.
  localparam int Cols    = 800;
  localparam int ActCols = 640;
  localparam int HFp     = 18;
  localparam int HBp     = 50;
  localparam int Rows    = 12;
  localparam int ActRows = 6;
  localparam int VFp     = 2;
  localparam int VBp     = 2;
  localparam int HsLen   = 92;
  localparam int NumVecs = 15;
  localparam logic [14:0] IdleVal = {1'b0, 1'b1, 1'b1, 12'h000};

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       hs    = 1'b0;
  logic       vs    = 1'b0;
  logic [3:0] r_in  = 4'h0;
  logic [3:0] g_in  = 4'h0;
  logic [3:0] b_in  = 4'h0;
  logic       o_hs, o_vs, o_lock;
  logic [3:0] o_r, o_g, o_b;

  vga_sync_porch #(
    .TOTAL_COLS    (Cols),
    .TOTAL_ROWS    (Rows),
    .ACTIVE_COLS   (ActCols),
    .ACTIVE_ROWS   (ActRows),
    .H_FRONT_PORCH (HFp),
    .H_BACK_PORCH  (HBp),
    .V_FRONT_PORCH (VFp),
    .V_BACK_PORCH  (VBp),
    .VIDEO_WIDTH   (4)
  ) dut (
    .i_Clk       (clk),
    .i_Rst_L     (rst_n),
    .i_HSync     (hs),
    .i_VSync     (vs),
    .i_Red_Video (r_in),
    .i_Grn_Video (g_in),
    .i_Blu_Video (b_in),
    .o_HSync     (o_hs),
    .o_VSync     (o_vs),
    .o_Red_Video (o_r),
    .o_Grn_Video (o_g),
    .o_Blu_Video (o_b),
    .o_Locked    (o_lock)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] val;  // {locked, hsync, vsync, red, grn, blu}
    int          col;
    int          row;
    string       name;
  } exp_t;

  typedef struct {
    int         col;
    int         row;
    logic       hs;
    logic       vs;
    logic [3:0] red;
    string      name;
  } vec_t;

  vec_t vecs[NumVecs];
  int   vec_hits[NumVecs];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   g_col  = 0;
  int   g_row  = 0;
  logic locked = 1'b0;
  logic prev_vs = 1'b1;
  int   hs_run = 0;

  function automatic vec_t mk(input int c, input int rw, input logic h, input logic v,
                              input logic [3:0] red, input string n);
    vec_t t;
    t.col = c; t.row = rw; t.hs = h; t.vs = v; t.red = red; t.name = n;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [14:0] outs();
    return {o_lock, o_hs, o_vs, o_r, o_g, o_b};
  endfunction

  task automatic reseed();
    exp_t e;
    sb.delete();
    e.val = IdleVal; e.col = -1; e.row = -1; e.name = "after_reset";
    sb.push_back(e);
    sb.push_back(e);
    locked  = 1'b0;
    prev_vs = 1'b1;
    hs_run  = 0;
  endtask

  task automatic advance();
    g_col++;
    if (g_col == Cols) begin
      g_col = 0;
      g_row++;
      if (g_row == Rows) g_row = 0;
    end
  endtask

  task automatic set_video();
    r_in = 4'hF;
    g_in = 4'(g_col);
    b_in = 4'(g_row) ^ 4'h9;
  endtask

  // Drive one pixel, queue its expected outputs, and compare the pixel from two cycles ago.
  task automatic drive(input logic hs_v, input logic vs_v);
    exp_t       e, got;
    logic       ehs, evs;
    logic [3:0] er, eg, eb;
    string      nm;
    if (vs_v && !prev_vs) begin
      g_col  = 0;
      g_row  = 0;
      locked = 1'b1;
    end
    prev_vs = vs_v;
    hs = hs_v;
    vs = vs_v;
    set_video();
    ehs = 1'b1; evs = 1'b1; er = 4'h0; eg = 4'h0; eb = 4'h0; nm = "idle";
    if (locked) begin
      nm  = "stream";
      ehs = !((g_col >= ActCols + HFp) && (g_col < Cols - HBp));
      evs = !((g_row >= ActRows + VFp) && (g_row < Rows - VBp));
      if ((g_col < ActCols) && (g_row < ActRows)) begin
        er = r_in; eg = g_in; eb = b_in;
      end
      for (int i = 0; i < NumVecs; i++) begin
        if ((vecs[i].col == g_col) && (vecs[i].row == g_row)) begin
          ehs = vecs[i].hs;
          evs = vecs[i].vs;
          er  = vecs[i].red;
          if (vecs[i].red == 4'h0) begin
            eg = 4'h0; eb = 4'h0;
          end
          nm = vecs[i].name;
          vec_hits[i]++;
        end
      end
    end
    e.val = {locked, ehs, evs, er, eg, eb};
    e.col = g_col; e.row = g_row; e.name = nm;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 3) begin
      got = sb.pop_front();
      check($sformatf("pix %s r%0d c%0d", got.name, got.row, got.col), 32'(outs()),
            32'(got.val));
    end
    if (o_hs === 1'b0) begin
      hs_run++;
    end else begin
      if (hs_run != 0) check("hsync_low_len", hs_run, HsLen);
      hs_run = 0;
    end
    @(posedge clk);
    #1;
    advance();
  endtask

  task automatic stream_n(input int n);
    for (int k = 0; k < n; k++) drive(g_col < ActCols, g_row < ActRows);
  endtask

  task automatic stream_until(input int c, input int rw);
    for (int k = 0; k < 2 * Cols * Rows && !((g_col == c) && (g_row == rw)); k++) begin
      drive(g_col < ActCols, g_row < ActRows);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    hs = 1'b0;
    vs = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    reseed();
  endtask

  initial begin
    vecs[0]  = mk(657, 1, 1'b1, 1'b1, 4'h0, "hs_657");
    vecs[1]  = mk(658, 1, 1'b0, 1'b1, 4'h0, "hs_658");
    vecs[2]  = mk(749, 1, 1'b0, 1'b1, 4'h0, "hs_749");
    vecs[3]  = mk(750, 1, 1'b1, 1'b1, 4'h0, "hs_750");
    vecs[4]  = mk(639, 5, 1'b1, 1'b1, 4'hF, "vid_639");
    vecs[5]  = mk(640, 5, 1'b1, 1'b1, 4'h0, "vid_640");
    vecs[6]  = mk(0,   6, 1'b1, 1'b1, 4'h0, "row_6");
    vecs[7]  = mk(799, 7, 1'b1, 1'b1, 4'h0, "vs_before");
    vecs[8]  = mk(0,   8, 1'b1, 1'b0, 4'h0, "vs_first");
    vecs[9]  = mk(799, 9, 1'b1, 1'b0, 4'h0, "vs_last");
    vecs[10] = mk(0,  10, 1'b1, 1'b1, 4'h0, "vs_after");
    vecs[11] = mk(700, 9, 1'b0, 1'b0, 4'h0, "hs_vs_both");
    vecs[12] = mk(799, 11, 1'b1, 1'b1, 4'h0, "frame_last");
    vecs[13] = mk(0,   0, 1'b1, 1'b1, 4'hF, "frame_first");
    vecs[14] = mk(0,   1, 1'b1, 1'b1, 4'hF, "line_wrap");
    for (int i = 0; i < NumVecs; i++) vec_hits[i] = 0;

    // No frame start: everything idle.
    do_reset();
    repeat (2000) drive(1'b0, 1'b0);

    // First frame start at cycle 10 after reset, then a full frame and a wrap.
    do_reset();
    repeat (10) drive(1'b0, 1'b0);
    g_col = 0;
    g_row = 0;
    stream_n(Cols * Rows);

    // Misaligned source: frame start injected at col 300.
    stream_until(299, 3);
    drive(1'b1, 1'b0);
    stream_n(Cols * Rows);

    // Reset pulse mid-frame for 3 cycles.
    stream_until(400, 4);
    rst_n = 1'b0;
    hs = 1'b1;
    vs = 1'b1;
    set_video();
    #1;
    check("async_reset", 32'(outs()), 32'(IdleVal));
    for (int k = 0; k < 3; k++) begin
      hs = (g_col < ActCols);
      vs = (g_row < ActRows);
      set_video();
      @(negedge clk);
      check($sformatf("reset_hold_%0d", k), 32'(outs()), 32'(IdleVal));
      @(posedge clk);
      #1;
      advance();
    end
    rst_n = 1'b1;
    reseed();
    stream_until(0, 0);
    stream_n(Cols * Rows + 2 * Cols);

    for (int i = 0; i < NumVecs; i++) begin
      check($sformatf("vec_seen_%s", vecs[i].name), 32'(vec_hits[i] > 0), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
